// File: rtl/def.sv
// def: shared memory-bus request/response types plus arbiter state and master ids.
package def;
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } memreq;

    typedef struct packed {
        logic [31:0] data;
    } memresp;

    typedef enum logic {IDLE, WAIT_RESP} arb_state_t;

    localparam logic MASTER_FETCH = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;
endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: single-entry request holder; a capture on a full slot is dropped and flagged.
module mem_req_slot
    import def::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  capture,
    input  memreq req_in,
    input  logic  clear,
    output logic  valid,
    output memreq req,
    output logic  overrun
);
    // clear-then-set: a capture coinciding with the clear is accepted
    always_comb overrun = capture && valid && !clear;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            req   <= '0;
        end else begin
            if (capture && !overrun) req <= req_in;
            valid <= capture || (valid && !clear);
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter serialising fetch and mem-stage requests onto one slave
// bus with a single outstanding transaction and an optional response timeout.
module mem_bus_arbiter
    import def::*;
#(
    parameter int TIMEOUT  = 0,
    parameter int TO_WIDTH = 16
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   f_request_enable,
    input  memreq  f_request,
    output logic   f_response_enable,
    output memresp f_response,
    input  logic   d_request_enable,
    input  memreq  d_request,
    output logic   d_response_enable,
    output memresp d_response,
    output logic   m_request_enable,
    output memreq  m_request,
    input  logic   m_response_enable,
    input  memresp m_response,
    output logic   busy,
    output logic   err
);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    arb_state_t          state, state_n;
    logic                owner, last_grant;
    logic [TO_WIDTH-1:0] to_cnt, to_cnt_n;
    logic                f_valid, d_valid, f_over, d_over;
    memreq               f_slot, d_slot;
    logic                grant_d, grant_f, timed_out, done, f_clear, d_clear;
    memresp              resp_data;

    mem_req_slot u_f_slot (
        .clk(clk), .rstn(rstn), .capture(f_request_enable), .req_in(f_request),
        .clear(f_clear), .valid(f_valid), .req(f_slot), .overrun(f_over)
    );

    mem_req_slot u_d_slot (
        .clk(clk), .rstn(rstn), .capture(d_request_enable), .req_in(d_request),
        .clear(d_clear), .valid(d_valid), .req(d_slot), .overrun(d_over)
    );

    always_comb begin
        timed_out = TIMEOUT != 0 && state == WAIT_RESP && to_cnt == TO_LAST && !m_response_enable;
        done      = state == WAIT_RESP && (m_response_enable || timed_out);
        f_clear   = done && owner == MASTER_FETCH;
        d_clear   = done && owner == MASTER_DATA;
        grant_d   = state == IDLE && d_valid && (!f_valid || last_grant == MASTER_FETCH);
        grant_f   = state == IDLE && f_valid && !grant_d;
        state_n   = (grant_d || grant_f) ? WAIT_RESP : done ? IDLE : state;
        to_cnt_n  = (state == WAIT_RESP && !done) ? to_cnt + 1'b1 : '0;
        resp_data = m_response_enable ? m_response : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_n;
            to_cnt <= to_cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner             <= MASTER_FETCH;
            last_grant        <= MASTER_FETCH;
            m_request_enable  <= 1'b0;
            m_request         <= '0;
            f_response_enable <= 1'b0;
            f_response        <= '0;
            d_response_enable <= 1'b0;
            d_response        <= '0;
            err               <= 1'b0;
        end else begin
            m_request_enable <= grant_d || grant_f;
            if (grant_d || grant_f) begin
                m_request  <= grant_d ? d_slot : f_slot;
                owner      <= grant_d ? MASTER_DATA : MASTER_FETCH;
                last_grant <= grant_d ? MASTER_DATA : MASTER_FETCH;
            end
            f_response_enable <= f_clear;
            d_response_enable <= d_clear;
            if (f_clear) f_response <= resp_data;
            if (d_clear) d_response <= resp_data;
            err <= err || f_over || d_over || timed_out || (state == IDLE && m_response_enable);
        end
    end

    assign busy = state == WAIT_RESP;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, routing, overrun, timeout and async reset.
module tb_mem_bus_arbiter;
    import def::*;

    logic   clk = 1'b0;
    logic   rstn = 1'b0;
    logic   f_request_enable = 1'b0, d_request_enable = 1'b0, m_response_enable = 1'b0;
    memreq  f_request = '0, d_request = '0;
    memresp m_response = '0;
    logic   f_response_enable, d_response_enable, m_request_enable, busy, err;
    memresp f_response, d_response;
    memreq  m_request;
    int     checks = 0, errors = 0;

    localparam logic [31:0] F_ADDR = 32'h100;
    localparam logic [31:0] D_ADDR = 32'h200;

    mem_bus_arbiter #(.TIMEOUT(8), .TO_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .f_request_enable(f_request_enable), .f_request(f_request),
        .f_response_enable(f_response_enable), .f_response(f_response),
        .d_request_enable(d_request_enable), .d_request(d_request),
        .d_response_enable(d_response_enable), .d_response(d_response),
        .m_request_enable(m_request_enable), .m_request(m_request),
        .m_response_enable(m_response_enable), .m_response(m_response),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        f_request_enable = 1'b0;
        d_request_enable = 1'b0;
        m_response_enable = 1'b0;
        #1;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic wait_grant(string tag);
        int n = 0;
        while (!m_request_enable && n < 10) begin
            step();
            n++;
        end
        chk(tag, m_request_enable, 1);
    endtask

    initial begin
        memreq exp_req;
        int    grants;
        logic  d_turn;
        // reset state
        do_reset();
        chk("rst_mreq_en", m_request_enable, 0);
        chk("rst_mreq", m_request, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_fresp", f_response, 0);
        chk("rst_dresp", d_response, 0);

        // single mem load
        d_request = '{mode: MEMREQ_READ, addr: 32'h1000, wstrb: 4'b0000, wdata: 32'h0};
        d_request_enable = 1'b1;
        step();
        d_request_enable = 1'b0;
        chk("load_not_yet", m_request_enable, 0);
        step();
        chk("load_grant", m_request_enable, 1);
        chk("load_addr", m_request.addr, 32'h1000);
        chk("load_mode", m_request.mode, MEMREQ_READ);
        chk("load_busy", busy, 1);
        step();
        chk("load_pulse_once", m_request_enable, 0);
        step();
        m_response_enable = 1'b1;
        m_response.data = 32'hDEADBEEF;
        step();
        m_response_enable = 1'b0;
        chk("load_dresp_en", d_response_enable, 1);
        chk("load_dresp", d_response.data, 32'hDEADBEEF);
        chk("load_fresp_en", f_response_enable, 0);
        chk("load_idle", busy, 0);
        step();
        chk("load_dresp_pulse", d_response_enable, 0);
        chk("load_dresp_hold", d_response.data, 32'hDEADBEEF);
        chk("load_err", err, 0);

        // simultaneous requests: mem wins the first tie
        do_reset();
        f_request = '{mode: MEMREQ_READ, addr: 32'h0, wstrb: 4'b0000, wdata: 32'h0};
        exp_req = '{mode: MEMREQ_WRITE, addr: 32'h2003, wstrb: 4'b1000, wdata: 32'hAB000000};
        d_request = exp_req;
        f_request_enable = 1'b1;
        d_request_enable = 1'b1;
        step();
        f_request_enable = 1'b0;
        d_request_enable = 1'b0;
        step();
        chk("sim_grant", m_request_enable, 1);
        chk("sim_store", m_request, exp_req);
        m_response_enable = 1'b1;
        m_response.data = 32'h11;
        step();
        m_response_enable = 1'b0;
        chk("sim_dresp_en", d_response_enable, 1);
        chk("sim_fresp_en0", f_response_enable, 0);
        step();
        chk("sim_fgrant", m_request_enable, 1);
        chk("sim_faddr", m_request.addr, 32'h0);
        m_response_enable = 1'b1;
        m_response.data = 32'h22;
        step();
        m_response_enable = 1'b0;
        chk("sim_fresp_en", f_response_enable, 1);
        chk("sim_fresp", f_response.data, 32'h22);
        chk("sim_dresp_en0", d_response_enable, 0);

        // round robin with owner re-requesting on its response edge
        do_reset();
        f_request = '{mode: MEMREQ_READ, addr: F_ADDR, wstrb: 4'b0, wdata: 32'h0};
        d_request = '{mode: MEMREQ_READ, addr: D_ADDR, wstrb: 4'b0, wdata: 32'h0};
        f_request_enable = 1'b1;
        d_request_enable = 1'b1;
        step();
        f_request_enable = 1'b0;
        d_request_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_turn = (k % 2) == 0;
            wait_grant("rr_grant");
            chk("rr_addr", m_request.addr, d_turn ? D_ADDR : F_ADDR);
            m_response_enable = 1'b1;
            m_response.data = 32'(k + 1);
            d_request_enable = d_turn;
            f_request_enable = !d_turn;
            step();
            m_response_enable = 1'b0;
            d_request_enable = 1'b0;
            f_request_enable = 1'b0;
            chk("rr_dresp_en", d_response_enable, d_turn);
            chk("rr_fresp_en", f_response_enable, !d_turn);
        end
        chk("rr_err", err, 0);

        // overrun on the fetch slot
        do_reset();
        grants = 0;
        f_request = '{mode: MEMREQ_READ, addr: 32'h300, wstrb: 4'b0, wdata: 32'h0};
        f_request_enable = 1'b1;
        step();
        grants += int'(m_request_enable);
        f_request = '{mode: MEMREQ_READ, addr: 32'h304, wstrb: 4'b0, wdata: 32'h0};
        step();
        f_request_enable = 1'b0;
        grants += int'(m_request_enable);
        chk("ovr_err", err, 1);
        chk("ovr_addr", m_request.addr, 32'h300);
        m_response_enable = 1'b1;
        step();
        m_response_enable = 1'b0;
        grants += int'(m_request_enable);
        for (int i = 0; i < 6; i++) begin
            step();
            grants += int'(m_request_enable);
        end
        chk("ovr_grants", grants, 1);

        // timeout after a prior nonzero response
        do_reset();
        d_request = '{mode: MEMREQ_READ, addr: 32'h400, wstrb: 4'b0, wdata: 32'h0};
        d_request_enable = 1'b1;
        step();
        d_request_enable = 1'b0;
        wait_grant("to_grant1");
        m_response_enable = 1'b1;
        m_response.data = 32'h55;
        step();
        m_response_enable = 1'b0;
        chk("to_first", d_response.data, 32'h55);
        d_request_enable = 1'b1;
        step();
        d_request_enable = 1'b0;
        wait_grant("to_grant2");
        for (int i = 0; i < 7; i++) step();
        chk("to_wait_busy", busy, 1);
        chk("to_wait_en", d_response_enable, 0);
        chk("to_wait_err", err, 0);
        step();
        chk("to_en", d_response_enable, 1);
        chk("to_data", d_response.data, 32'h0);
        chk("to_err", err, 1);
        chk("to_idle", busy, 0);
        chk("to_fen", f_response_enable, 0);

        // asynchronous reset in the middle of a transaction
        do_reset();
        f_request = '{mode: MEMREQ_READ, addr: 32'h500, wstrb: 4'b0, wdata: 32'h0};
        f_request_enable = 1'b1;
        step();
        f_request_enable = 1'b0;
        wait_grant("mid_grant");
        chk("mid_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mreq_en", m_request_enable, 0);
        chk("mid_rst_fen", f_response_enable, 0);
        chk("mid_rst_den", d_response_enable, 0);
        rstn = 1'b1;
        step();
        m_response_enable = 1'b1;
        m_response.data = 32'h77;
        step();
        m_response_enable = 1'b0;
        chk("mid_spur_err", err, 1);
        chk("mid_spur_fen", f_response_enable, 0);
        chk("mid_spur_den", d_response_enable, 0);
        chk("mid_spur_grant", m_request_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
